swd_target_dp: RTL

SWD target-side Debug Port (SW-DP responder) and the far end of the SWD initiator link. It oversamples SWCLK/SWDIO in the CLK domain, parses 8-bit requests, and drives ACK and read data. DP registers are implemented internally. AP accesses are forwarded to a single-outstanding AP request port with posted-read (RDBUFF) semantics. It is used as an on-chip target model and in loopback test rigs.

---
 rtl/swd_pkg.sv | 19 +
 rtl/swd_target_sync.sv | 32 +++
 rtl/swd_target_dp.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/swd_pkg.sv
// swd_pkg: shared SWD target types (ACK codes, FSM states), DP register addresses and CTRL/STAT bit positions
package swd_pkg;
  typedef enum logic [2:0] {
    ACK_OK    = 3'b001,
    ACK_WAIT  = 3'b010,
    ACK_FAULT = 3'b100
  } ack_t;
  typedef enum logic [2:0] {IDLE, REQ, TRN1, ACK, RDATA, TRN2, WDATA, ERR} state_t;
  localparam logic [1:0] DP_IDCODE   = 2'd0;
  localparam logic [1:0] DP_CTRLSTAT = 2'd1;
  localparam logic [1:0] DP_SELECT   = 2'd2;
  localparam logic [1:0] DP_RDBUFF   = 2'd3;
  localparam int CS_STICKYERR     = 5;
  localparam int CS_WDATAERR      = 7;
  localparam int CS_CDBGPWRUPREQ  = 28;
  localparam int CS_CDBGPWRUPACK  = 29;
  localparam int CS_CSYSPWRUPREQ  = 30;
  localparam int CS_CSYSPWRUPACK  = 31;
endpackage

// File: rtl/swd_target_sync.sv
// swd_target_sync: synchronises swclk/swdio into clk (in: clk, rst, swclk, swdio; out: rise = one-clk pulse on synced swclk 0->1, din = synced swdio)
module swd_target_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic swclk,
  input  logic swdio,
  output logic rise,
  output logic din
);
  logic [STAGES-1:0] clk_sync_q, clk_sync_d, dio_sync_q, dio_sync_d;
  logic clk_prev_q, clk_prev_d;
  always_comb begin
    clk_sync_d = {clk_sync_q[STAGES-2:0], swclk};
    dio_sync_d = {dio_sync_q[STAGES-2:0], swdio};
    clk_prev_d = clk_sync_q[STAGES-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '0;
      dio_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dio_sync_q <= dio_sync_d;
      clk_prev_q <= clk_prev_d;
    end
  end
  assign rise = clk_sync_q[STAGES-1] & ~clk_prev_q;
  assign din  = dio_sync_q[STAGES-1];
endmodule

// File: rtl/swd_target_dp.sv
// swd_target_dp: SW-DP responder (in: CLK, RESET, SWCLK, SWDIOIN, AP_ACK/AP_RDATA/AP_ERR; out: SWDIOOUT/SWDIOOE, AP_REQ/AP_RnW/AP_ADDR/AP_WDATA single-outstanding posted AP port)
module swd_target_dp
  import swd_pkg::*;
#(
  parameter logic [31:0] IDCODE      = 32'h2BA01477,
  parameter int          SYNC_STAGES = 2,
  parameter int          RESET_ONES  = 50
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SWCLK,
  input  logic        SWDIOIN,
  output logic        SWDIOOUT,
  output logic        SWDIOOE,
  output logic        AP_REQ,
  output logic        AP_RnW,
  output logic [7:0]  AP_ADDR,
  output logic [31:0] AP_WDATA,
  input  logic        AP_ACK,
  input  logic [31:0] AP_RDATA,
  input  logic        AP_ERR
);
  localparam int OW = $clog2(RESET_ONES + 1);
  logic rise, din;
  state_t state_q, state_d;
  ack_t ack_q, ack_d;
  logic [5:0] cnt_q, cnt_d, req_q, req_d;
  logic [31:0] sh_q, sh_d, rdbuff_q, rdbuff_d, ap_wdata_q, ap_wdata_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [3:0] select_q, select_d;
  logic [7:0] ap_addr_q, ap_addr_d;
  logic par_q, par_d, lockout_q, lockout_d, sticky_q, sticky_d, wderr_q, wderr_d;
  logic cdbg_q, cdbg_d, csys_q, csys_d, out_q, out_d, oe_q, oe_d;
  logic ap_req_q, ap_req_d, ap_rnw_q, ap_rnw_d;
  logic [2:0] ack_v;
  logic [31:0] ctrl_stat, dp_rdata, rd_data;
  logic valid, pending, err_now, line_reset, idcode_rd;
  swd_target_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (CLK),
    .rst  (RESET),
    .swclk(SWCLK),
    .swdio(SWDIOIN),
    .rise (rise),
    .din  (din)
  );
  assign ack_v      = ack_q;
  assign ctrl_stat  = {csys_q, csys_q, cdbg_q, cdbg_q, 20'd0, wderr_q, 1'b0, sticky_q, 5'd0};
  assign dp_rdata   = req_q[3:2] == DP_IDCODE   ? IDCODE :
                      req_q[3:2] == DP_CTRLSTAT ? ctrl_stat :
                      req_q[3:2] == DP_RDBUFF   ? rdbuff_q : 32'd0;
  assign rd_data    = req_q[0] ? rdbuff_q : dp_rdata;
  assign valid      = ~^req_q[4:0] & ~req_q[5] & din;
  assign idcode_rd  = req_q[3:0] == 4'b0010;
  assign pending    = ap_req_q & ~AP_ACK;
  assign err_now    = sticky_q | wderr_q | (AP_ACK & AP_ERR);
  assign ones_d     = rise & ~oe_q ? (din ? (ones_q == OW'(RESET_ONES) ? ones_q : ones_q + 1'b1) : '0) : ones_q;
  assign line_reset = rise & ~oe_q & din & (ones_d == OW'(RESET_ONES));
  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    sh_d       = sh_q;
    par_d      = par_q;
    lockout_d  = lockout_q;
    sticky_d   = sticky_q;
    wderr_d    = wderr_q;
    cdbg_d     = cdbg_q;
    csys_d     = csys_q;
    select_d   = select_q;
    rdbuff_d   = rdbuff_q;
    out_d      = out_q;
    oe_d       = oe_q;
    ap_req_d   = ap_req_q;
    ap_rnw_d   = ap_rnw_q;
    ap_addr_d  = ap_addr_q;
    ap_wdata_d = ap_wdata_q;
    if (AP_ACK) begin
      ap_req_d = 1'b0;
      rdbuff_d = ap_rnw_q ? AP_RDATA : rdbuff_q;
      sticky_d = sticky_q | AP_ERR;
    end
    if (rise) begin
      case (state_q)
        IDLE: begin
          state_d = din ? REQ : IDLE;
          cnt_d   = '0;
        end
        REQ: begin
          if (cnt_q != 6'd6) begin
            req_d = {din, req_q[5:1]};
            cnt_d = cnt_q + 6'd1;
          end else if (!valid) begin
            state_d   = ERR;
            lockout_d = 1'b1;
          end else if (lockout_q && !idcode_rd) begin
            state_d = IDLE;
          end else begin
            state_d = TRN1;
            ack_d   = !req_q[0] ? ACK_OK : err_now ? ACK_FAULT : pending ? ACK_WAIT : ACK_OK;
          end
        end
        TRN1: begin
          oe_d    = 1'b1;
          out_d   = ack_v[0];
          cnt_d   = 6'd1;
          state_d = ACK;
        end
        ACK: begin
          if (cnt_q != 6'd3) begin
            out_d = ack_v[cnt_q[1:0]];
            cnt_d = cnt_q + 6'd1;
          end else if (ack_q != ACK_OK) begin
            oe_d    = 1'b0;
            out_d   = 1'b0;
            state_d = IDLE;
          end else if (req_q[1]) begin
            out_d     = rd_data[0];
            sh_d      = rd_data >> 1;
            par_d     = ^rd_data;
            cnt_d     = 6'd1;
            state_d   = RDATA;
            lockout_d = lockout_q & ~idcode_rd;
          end else begin
            oe_d    = 1'b0;
            out_d   = 1'b0;
            state_d = TRN2;
          end
        end
        RDATA: begin
          if (cnt_q < 6'd32) begin
            out_d = sh_q[0];
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + 6'd1;
          end else if (cnt_q == 6'd32) begin
            out_d = par_q;
            cnt_d = 6'd33;
          end else begin
            oe_d    = 1'b0;
            out_d   = 1'b0;
            state_d = IDLE;
            if (req_q[0]) begin
              ap_req_d  = 1'b1;
              ap_rnw_d  = 1'b1;
              ap_addr_d = {select_q, req_q[3:2], 2'b00};
            end
          end
        end
        TRN2: begin
          sh_d    = {din, sh_q[31:1]};
          cnt_d   = 6'd1;
          state_d = WDATA;
        end
        WDATA: begin
          if (cnt_q != 6'd32) begin
            sh_d  = {din, sh_q[31:1]};
            cnt_d = cnt_q + 6'd1;
          end else begin
            state_d = IDLE;
            if (din != ^sh_q) begin
              wderr_d = 1'b1;
            end else if (req_q[0]) begin
              ap_req_d   = 1'b1;
              ap_rnw_d   = 1'b0;
              ap_addr_d  = {select_q, req_q[3:2], 2'b00};
              ap_wdata_d = sh_q;
            end else if (req_q[3:2] == DP_IDCODE) begin
              ap_req_d = ap_req_d & ~sh_q[0];
              sticky_d = sticky_d & ~sh_q[2];
              wderr_d  = wderr_q & ~sh_q[3];
            end else if (req_q[3:2] == DP_CTRLSTAT) begin
              cdbg_d = sh_q[CS_CDBGPWRUPREQ];
              csys_d = sh_q[CS_CSYSPWRUPREQ];
            end else if (req_q[3:2] == DP_SELECT) begin
              select_d = sh_q[7:4];
            end
          end
        end
        default: ;
      endcase
    end
    if (line_reset) begin
      state_d   = IDLE;
      lockout_d = 1'b1;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      ack_q      <= ACK_OK;
      cnt_q      <= '0;
      req_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      ones_q     <= '0;
      lockout_q  <= 1'b1;
      sticky_q   <= 1'b0;
      wderr_q    <= 1'b0;
      cdbg_q     <= 1'b0;
      csys_q     <= 1'b0;
      select_q   <= '0;
      rdbuff_q   <= '0;
      out_q      <= 1'b0;
      oe_q       <= 1'b0;
      ap_req_q   <= 1'b0;
      ap_rnw_q   <= 1'b0;
      ap_addr_q  <= '0;
      ap_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      ones_q     <= ones_d;
      lockout_q  <= lockout_d;
      sticky_q   <= sticky_d;
      wderr_q    <= wderr_d;
      cdbg_q     <= cdbg_d;
      csys_q     <= csys_d;
      select_q   <= select_d;
      rdbuff_q   <= rdbuff_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      ap_req_q   <= ap_req_d;
      ap_rnw_q   <= ap_rnw_d;
      ap_addr_q  <= ap_addr_d;
      ap_wdata_q <= ap_wdata_d;
    end
  end
  assign SWDIOOUT = out_q;
  assign SWDIOOE  = oe_q;
  assign AP_REQ   = ap_req_q;
  assign AP_RnW   = ap_rnw_q;
  assign AP_ADDR  = ap_addr_q;
  assign AP_WDATA = ap_wdata_q;
endmodule
